// File: rtl/sdram_rd_engine.sv
// SDRAM read sequencer: one request -> ACT/READ/BST/PRE, returned burst captured with a valid strobe.
// Build option SDR_RD_OPEN_ROW_EN keeps rows open between bursts using a per-bank open-row table.
module sdram_rd_engine #(
    parameter int DATA_W  = 16,
    parameter int BANK_W  = 2,
    parameter int ROW_W   = 13,
    parameter int COL_W   = 9,
    parameter int BURST_W = 10,
    parameter int T_RCD   = 2,
    parameter int CAS_LAT = 3,
    parameter int T_RP    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_end,
    input  logic                          rd_req,
    input  logic [BANK_W+ROW_W+COL_W-1:0] rd_addr,
    input  logic [BURST_W-1:0]            rd_burst_len,
    input  logic                          close_req,
    output logic                          rd_gnt,
    output logic                          rd_busy,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_end,
    output logic                          close_done,
    input  logic [DATA_W-1:0]             rd_sdram_dq,
    output logic [3:0]                    rd_sdram_cmd,
    output logic [BANK_W-1:0]             rd_sdram_bank,
    output logic [ROW_W-1:0]              rd_sdram_addr
);
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int CNT_W  = BURST_W + 2;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    localparam logic [ROW_W-1:0] A10_ONLY   = ROW_W'(11'h400);
    localparam logic [CNT_W-1:0] TRCD_LAST  = CNT_W'(T_RCD - 2);
    localparam logic [CNT_W-1:0] CL_LAST    = CNT_W'(CAS_LAT - 1);
    localparam logic [CNT_W-1:0] TRP_LAST   = CNT_W'(T_RP - 1);
`ifdef SDR_RD_OPEN_ROW_EN
    localparam int               NBANK      = 1 << BANK_W;
    localparam logic [CNT_W-1:0] TRP_ACT_LAST = CNT_W'(T_RP - 2);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_TRCD, S_READ, S_CL, S_DATA,
        S_PRE, S_TRP, S_END, S_CLOSE, S_CLOSE_TRP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BANK_W-1:0]    bank_q, bank_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [BURST_W-1:0]   len_q, len_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [BANK_W-1:0]    sd_bank_q, sd_bank_d;
    logic [ROW_W-1:0]     sd_addr_q, sd_addr_d;
    logic                 gnt_q, gnt_d, busy_q, busy_d, valid_q, valid_d;
    logic                 end_q, end_d, cdone_q, cdone_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 capture;
`ifdef SDR_RD_OPEN_ROW_EN
    logic [NBANK-1:0]     open_vld_q, open_vld_d;
    logic [ROW_W-1:0]     open_row_q [NBANK];
    logic [ROW_W-1:0]     open_row_d [NBANK];
`endif

    logic [BANK_W-1:0]    in_bank;
    logic [ROW_W-1:0]     in_row;
    logic [CNT_W-1:0]     len_ext, len_m1, bst_in_data;

    assign in_bank     = rd_addr[ADDR_W-1 -: BANK_W];
    assign in_row      = rd_addr[COL_W +: ROW_W];
    assign len_ext     = CNT_W'(len_q);
    assign len_m1      = len_ext - CNT_W'(1);
    // BST lands at READ+L, which falls either inside the CAS wait or inside the data phase.
    assign bst_in_data = len_m1 - CNT_W'(CAS_LAT);

    always_comb begin
        // NOTE: every variable gets a default here so no path through the case infers a latch.
        state_d   = state_q;
        bank_d    = bank_q;
        row_d     = row_q;
        col_d     = col_q;
        len_d     = len_q;
        cmd_d     = CMD_NOP;
        sd_bank_d = '1;
        sd_addr_d = '1;
        gnt_d     = 1'b0;
        end_d     = 1'b0;
        cdone_d   = 1'b0;
        capture   = 1'b0;
`ifdef SDR_RD_OPEN_ROW_EN
        open_vld_d = open_vld_q;
        open_row_d = open_row_q;
`endif
        case (state_q)
            S_IDLE: if (init_end) begin
                if (close_req) begin
                    state_d = S_CLOSE;
                end else if (rd_req) begin
                    gnt_d  = 1'b1;
                    bank_d = in_bank;
                    row_d  = in_row;
                    col_d  = rd_addr[COL_W-1:0];
                    len_d  = (rd_burst_len == '0) ? BURST_W'(1) : rd_burst_len;
`ifdef SDR_RD_OPEN_ROW_EN
                    if (!open_vld_q[in_bank])                state_d = S_ACT;
                    else if (open_row_q[in_bank] == in_row)  state_d = S_READ;
                    else                                     state_d = S_PRE;
`else
                    state_d = S_ACT;
`endif
                end
            end
            S_ACT: begin
                cmd_d     = CMD_ACT;
                sd_bank_d = bank_q;
                sd_addr_d = row_q;
`ifdef SDR_RD_OPEN_ROW_EN
                open_vld_d[bank_q] = 1'b1;
                open_row_d[bank_q] = row_q;
`endif
                state_d = (T_RCD > 1) ? S_TRCD : S_READ;
            end
            S_TRCD: if (cnt_q == TRCD_LAST) state_d = S_READ;
            S_READ: begin
                cmd_d     = CMD_RD;
                sd_bank_d = bank_q;
                sd_addr_d = ROW_W'(col_q);
                state_d   = S_CL;
            end
            S_CL: begin
                if (cnt_q == len_m1) cmd_d = CMD_BST;
`ifdef SDR_RD_OPEN_ROW_EN
                if (cnt_q == CL_LAST) state_d = S_DATA;
`else
                if (cnt_q == CL_LAST) state_d = (len_q == BURST_W'(1)) ? S_PRE : S_DATA;
`endif
            end
            S_DATA: begin
                capture = 1'b1;
                if (cnt_q == bst_in_data) cmd_d = CMD_BST;
`ifdef SDR_RD_OPEN_ROW_EN
                if (cnt_q == len_m1) begin
                    state_d = S_END;
                    end_d   = 1'b1;
                end
`else
                if (cnt_q == len_ext - CNT_W'(2)) state_d = S_PRE;
`endif
            end
`ifdef SDR_RD_OPEN_ROW_EN
            // Row miss: close only the addressed bank, then reopen it on the new row.
            S_PRE: begin
                cmd_d     = CMD_PRE;
                sd_bank_d = bank_q;
                sd_addr_d = '0;
                open_vld_d[bank_q] = 1'b0;
                state_d   = (T_RP > 1) ? S_TRP : S_ACT;
            end
            S_TRP: if (cnt_q == TRP_ACT_LAST) state_d = S_ACT;
`else
            S_PRE: begin
                capture   = 1'b1;
                cmd_d     = CMD_PRE;
                sd_bank_d = bank_q;
                sd_addr_d = A10_ONLY;
                state_d   = S_TRP;
            end
            S_TRP: if (cnt_q == TRP_LAST) begin
                state_d = S_END;
                end_d   = 1'b1;
            end
`endif
            S_END: state_d = S_IDLE;
            S_CLOSE: begin
                cmd_d     = CMD_PRE;
                sd_addr_d = A10_ONLY;
`ifdef SDR_RD_OPEN_ROW_EN
                open_vld_d = '0;
`endif
                state_d   = S_CLOSE_TRP;
            end
            S_CLOSE_TRP: if (cnt_q == TRP_LAST) begin
                state_d = S_IDLE;
                cdone_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d   = (state_d != state_q || state_d == S_IDLE) ? '0 : cnt_q + CNT_W'(1);
        busy_d  = !(state_d inside {S_IDLE, S_CLOSE, S_CLOSE_TRP});
        valid_d = capture;
        data_d  = capture ? rd_sdram_dq : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            len_q     <= '0;
            cmd_q     <= CMD_NOP;
            sd_bank_q <= '1;
            sd_addr_q <= '1;
            gnt_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            cdone_q   <= 1'b0;
            data_q    <= '0;
`ifdef SDR_RD_OPEN_ROW_EN
            open_vld_q <= '0;
            for (int b = 0; b < NBANK; b++) open_row_q[b] <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            col_q     <= col_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            sd_bank_q <= sd_bank_d;
            sd_addr_q <= sd_addr_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            end_q     <= end_d;
            cdone_q   <= cdone_d;
            data_q    <= data_d;
`ifdef SDR_RD_OPEN_ROW_EN
            open_vld_q <= open_vld_d;
            open_row_q <= open_row_d;
`endif
        end
    end

    assign rd_gnt        = gnt_q;
    assign rd_busy       = busy_q;
    assign rd_valid      = valid_q;
    assign rd_data       = data_q;
    assign rd_end        = end_q;
    assign close_done    = cdone_q;
    assign rd_sdram_cmd  = cmd_q;
    assign rd_sdram_bank = sd_bank_q;
    assign rd_sdram_addr = sd_addr_q;
endmodule

// File: tb/tb_sdram_rd_engine.sv
// Directed bench for sdram_rd_engine: command timing, burst capture, reset and close handling.
// Expectations follow SDR_RD_OPEN_ROW_EN when the bench is built with that macro.
module tb_sdram_rd_engine;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RDC = 4'b0101, BST = 4'b0110, PRE = 4'b0010;
`ifdef SDR_RD_OPEN_ROW_EN
    localparam bit OPEN = 1'b1;
`else
    localparam bit OPEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, init_end, rd_req, close_req;
    logic [23:0] rd_addr;
    logic [9:0]  rd_burst_len;
    logic        rd_gnt, rd_busy, rd_valid, rd_end, close_done;
    logic [15:0] rd_data, rd_sdram_dq;
    logic [3:0]  rd_sdram_cmd;
    logic [1:0]  rd_sdram_bank;
    logic [12:0] rd_sdram_addr;

    int errors = 0, checks = 0, cyc = 0;
    int act_c, rd_c, bst_c, pre_c, gnt_c, end_c, cd_c, vfirst, vlast;
    int vcnt, derr, nop_err, ncmd, gnt_n, end_n, cd_n;
    int act_bank, act_row, rd_col, pre_bank, pre_a10;

    always #5 clk = ~clk;

    sdram_rd_engine dut (
        .clk(clk), .rst(rst), .init_end(init_end), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_burst_len(rd_burst_len), .close_req(close_req), .rd_gnt(rd_gnt), .rd_busy(rd_busy),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_end(rd_end), .close_done(close_done),
        .rd_sdram_dq(rd_sdram_dq), .rd_sdram_cmd(rd_sdram_cmd), .rd_sdram_bank(rd_sdram_bank),
        .rd_sdram_addr(rd_sdram_addr)
    );

    function automatic logic [15:0] pat(input int c);
        return 16'(c * 337) ^ 16'hC3A5;
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        act_c = -1; rd_c = -1; bst_c = -1; pre_c = -1; gnt_c = -1; end_c = -1; cd_c = -1;
        vfirst = -1; vlast = -1; vcnt = 0; derr = 0; nop_err = 0; ncmd = 0;
        gnt_n = 0; end_n = 0; cd_n = 0;
        act_bank = -1; act_row = -1; rd_col = -1; pre_bank = -1; pre_a10 = -1;
    endtask

    // One cycle: sample outputs mid-cycle, log events, then drive this cycle's DQ word.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rd_sdram_cmd != NOP) ncmd++;
        else if (rd_sdram_bank != 2'b11 || rd_sdram_addr != 13'h1FFF) nop_err++;
        case (rd_sdram_cmd)
            ACT: if (act_c < 0) begin act_c = cyc; act_bank = int'(rd_sdram_bank); act_row = int'(rd_sdram_addr); end
            RDC: if (rd_c < 0) begin rd_c = cyc; rd_col = int'(rd_sdram_addr); end
            BST: if (bst_c < 0) bst_c = cyc;
            PRE: if (pre_c < 0) begin pre_c = cyc; pre_bank = int'(rd_sdram_bank); pre_a10 = int'(rd_sdram_addr[10]); end
            default: ;
        endcase
        if (rd_gnt) begin gnt_n++; if (gnt_c < 0) gnt_c = cyc; end
        if (rd_end) begin end_n++; if (end_c < 0) end_c = cyc; end
        if (close_done) begin cd_n++; if (cd_c < 0) cd_c = cyc; end
        if (rd_valid) begin
            if (vfirst < 0) vfirst = cyc;
            vlast = cyc;
            vcnt++;
            if (rd_data !== pat(cyc - 1)) derr++;
        end else if (rd_data !== 16'h0) begin
            derr++;
        end
        rd_sdram_dq = pat(cyc);
    endtask

    task automatic start_req(input logic [23:0] a, input logic [9:0] len, input int hold);
        int n;
        rd_addr = a; rd_burst_len = len; rd_req = 1'b1;
        n = 0;
        while (gnt_n == 0 && n < 50) begin tick(); n++; end
        check("gnt_seen", gnt_n, 1);
        repeat (hold) tick();
        rd_req = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (end_n == 0 && n < budget) begin tick(); n++; end
        repeat (3) tick();
        check("end_once", end_n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; init_end = 1'b0; rd_req = 1'b0; close_req = 1'b0;
        rd_addr = '0; rd_burst_len = '0; rd_sdram_dq = '0;
        clear_log();
        tick(); tick();
        check("rst_cmd", rd_sdram_cmd, NOP);
        check("rst_bank", rd_sdram_bank, 2'b11);
        check("rst_addr", rd_sdram_addr, 13'h1FFF);
        check("rst_flags", {rd_gnt, rd_valid, rd_end, close_done, rd_busy}, 0);
        check("rst_data", rd_data, 0);
        rst = 1'b0;

        // Requests ignored before init completes.
        clear_log();
        rd_req = 1'b1; close_req = 1'b1; rd_addr = {2'd1, 13'h0055, 9'h010};
        repeat (6) tick();
        check("noinit_gnt", gnt_n, 0);
        check("noinit_close", cd_n, 0);
        check("noinit_cmds", ncmd, 0);
        rd_req = 1'b0; close_req = 1'b0; init_end = 1'b1;
        tick();

        // Basic L=4 burst; rd_req held into busy must not regrant.
        clear_log();
        start_req({2'd1, 13'h0055, 9'h010}, 10'd4, 5);
        wait_end(100);
        check("t1_act_bank", act_bank, 1);
        check("t1_act_row", act_row, 13'h0055);
        check("t1_read_at", rd_c, act_c + 2);
        check("t1_read_col", rd_col, 13'h0010);
        check("t1_bst_at", bst_c, act_c + 6);
        check("t1_vfirst", vfirst, act_c + 6);
        check("t1_vlast", vlast, act_c + 9);
        check("t1_vcnt", vcnt, 4);
        check("t1_pre_at", pre_c, OPEN ? -1 : act_c + 9);
        check("t1_pre_a10", pre_a10, OPEN ? -1 : 1);
        check("t1_end_at", end_c, OPEN ? act_c + 9 : act_c + 11);
        check("t1_data", derr, 0);
        check("t1_nop_bus", nop_err, 0);
        check("t1_ncmd", ncmd, OPEN ? 3 : 4);
        check("t1_no_regrant", gnt_n, 1);

        // L=0 behaves as a single word.
        clear_log();
        start_req({2'd3, 13'h0100, 9'h000}, 10'd0, 0);
        wait_end(100);
        check("t2_vcnt", vcnt, 1);
        check("t2_bst_at", bst_c, rd_c + 1);
        check("t2_vfirst", vfirst, rd_c + 4);
        check("t2_end_at", end_c, OPEN ? rd_c + 4 : rd_c + 6);
        check("t2_data", derr, 0);

        // Longest burst with a column that wraps in the page.
        clear_log();
        start_req({2'd2, 13'h1ABC, 9'h1F0}, 10'd1023, 0);
        wait_end(1200);
        check("t3_read_col", rd_col, 13'h01F0);
        check("t3_vcnt", vcnt, 1023);
        check("t3_vfirst", vfirst, rd_c + 4);
        check("t3_vlast", vlast, rd_c + 1026);
        check("t3_bst_at", bst_c, rd_c + 1023);
        check("t3_pre_at", pre_c, OPEN ? -1 : rd_c + 1026);
        check("t3_end_at", end_c, OPEN ? rd_c + 1026 : rd_c + 1028);
        check("t3_data", derr, 0);

        // Reset in the middle of the data phase.
        clear_log();
        begin
            int n;
            start_req({2'd1, 13'h0033, 9'h020}, 10'd8, 0);
            n = 0;
            while (vcnt == 0 && n < 30) begin tick(); n++; end
            check("t4_reached_data", (vcnt > 0) ? 1 : 0, 1);
        end
        rst = 1'b1;
        tick();
        check("t4_rst_cmd", rd_sdram_cmd, NOP);
        check("t4_rst_valid", rd_valid, 0);
        check("t4_rst_busy", rd_busy, 0);
        check("t4_rst_data", rd_data, 0);
        rst = 1'b0;
        clear_log();
        repeat (15) tick();
        check("t4_quiet_cmds", ncmd, 0);
        clear_log();
        start_req({2'd0, 13'h0ABC, 9'h003}, 10'd2, 0);
        wait_end(100);
        check("t4_act_row", act_row, 13'h0ABC);
        check("t4_read_at", rd_c, act_c + 2);
        check("t4_vcnt", vcnt, 2);
        check("t4_end_at", end_c, OPEN ? rd_c + 5 : rd_c + 7);

        // close_req wins over a simultaneous rd_req.
        clear_log();
        rd_addr = {2'd0, 13'h0200, 9'h008}; rd_burst_len = 10'd3;
        rd_req = 1'b1; close_req = 1'b1;
        begin
            int n;
            n = 0;
            while (cd_n == 0 && n < 20) begin tick(); n++; end
            close_req = 1'b0;
            n = 0;
            while (gnt_n == 0 && n < 20) begin tick(); n++; end
            rd_req = 1'b0;
        end
        wait_end(100);
        check("t5_close_once", cd_n, 1);
        check("t5_pre_a10", pre_a10, 1);
        check("t5_cd_at", cd_c, pre_c + 2);
        check("t5_gnt_at", gnt_c, cd_c + 1);
        check("t5_vcnt", vcnt, 3);

`ifdef SDR_RD_OPEN_ROW_EN
        clear_log();
        start_req({2'd1, 13'h0077, 9'h004}, 10'd2, 0);
        wait_end(100);
        check("o1_act_row", act_row, 13'h0077);
        clear_log();
        start_req({2'd1, 13'h0077, 9'h00C}, 10'd2, 0);
        wait_end(100);
        check("o2_no_act", act_c, -1);
        check("o2_read_at", rd_c, gnt_c + 1);
        check("o2_ncmd", ncmd, 2);
        check("o2_vcnt", vcnt, 2);
        check("o2_end_at", end_c, rd_c + 5);
        clear_log();
        start_req({2'd1, 13'h0078, 9'h004}, 10'd2, 0);
        wait_end(100);
        check("o3_pre_a10", pre_a10, 0);
        check("o3_pre_bank", pre_bank, 1);
        check("o3_act_at", act_c, pre_c + 2);
        check("o3_act_row", act_row, 13'h0078);
        check("o3_read_at", rd_c, act_c + 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
